// File: rtl/axil_wr_arbiter_2x1.sv
// Round-robin 2:1 AXI4-Lite write arbiter, one full AW+W+B transaction per grant; ARB_TIMEOUT_EN adds a per-grant timeout.
// Latency: grant registered one cycle after AW request, AW/W/B then pass through combinationally; ready/valid backpressure passes straight through.
module axil_wr_arbiter_2x1 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic [2:0]            s0_axil_awprot,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic [1:0]            s0_axil_bresp,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic [2:0]            s1_axil_awprot,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic [1:0]            s1_axil_bresp,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [1:0]            grant,
    output logic                  timeout_err
);
    typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t     state;
    logic       aw_done, w_done, last_grant;
    logic       sel, in_addr, in_resp, in_err, drain_now;
    logic       g_awvalid, g_wvalid, g_bready;
    logic       aw_rdy, w_rdy, b_vld, aw_hs, w_hs, b_hs, aw_fin, w_fin;
    logic [1:0] b_resp, pick;

    assign sel       = grant[1];
    assign in_addr   = (state == ADDR);
    assign in_resp   = (state == RESP);
    assign g_awvalid = sel ? s1_axil_awvalid : s0_axil_awvalid;
    assign g_wvalid  = sel ? s1_axil_wvalid  : s0_axil_wvalid;
    assign g_bready  = sel ? s1_axil_bready  : s0_axil_bready;

    assign m_axil_awaddr  = sel ? s1_axil_awaddr : s0_axil_awaddr;
    assign m_axil_awprot  = sel ? s1_axil_awprot : s0_axil_awprot;
    assign m_axil_wdata   = sel ? s1_axil_wdata  : s0_axil_wdata;
    assign m_axil_wstrb   = sel ? s1_axil_wstrb  : s0_axil_wstrb;
    assign m_axil_awvalid = in_addr & g_awvalid & ~aw_done;
    assign m_axil_wvalid  = in_addr & g_wvalid & ~w_done;
    assign m_axil_bready  = (in_resp & g_bready) | in_err | drain_now;

    // ERR swallows the pending AW/W locally and answers with SLVERR
    assign aw_rdy = (in_addr & m_axil_awready & ~aw_done) | (in_err & ~aw_done);
    assign w_rdy  = (in_addr & m_axil_wready & ~w_done) | (in_err & ~w_done);
    assign b_vld  = (in_resp & m_axil_bvalid) | in_err;
    assign b_resp = in_err ? 2'b10 : (in_resp ? m_axil_bresp : 2'b00);

    assign s0_axil_awready = grant[0] & aw_rdy;
    assign s0_axil_wready  = grant[0] & w_rdy;
    assign s0_axil_bvalid  = grant[0] & b_vld;
    assign s0_axil_bresp   = grant[0] ? b_resp : 2'b00;
    assign s1_axil_awready = grant[1] & aw_rdy;
    assign s1_axil_wready  = grant[1] & w_rdy;
    assign s1_axil_bvalid  = grant[1] & b_vld;
    assign s1_axil_bresp   = grant[1] ? b_resp : 2'b00;

    assign aw_hs  = g_awvalid & aw_rdy;
    assign w_hs   = g_wvalid & w_rdy;
    assign b_hs   = b_vld & g_bready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    always_comb begin
        pick = 2'b00;
        if (s0_axil_awvalid && s1_axil_awvalid) pick = last_grant ? 2'b01 : 2'b10;
        else if (s0_axil_awvalid)                pick = 2'b01;
        else if (s1_axil_awvalid)                pick = 2'b10;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    logic [CNT_W-1:0] cnt;
    logic             drain, expire;
    assign expire    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign in_err    = (state == ERR);
    assign drain_now = drain & (state == IDLE);
`else
    assign in_err      = 1'b0;
    assign drain_now   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            last_grant <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt         <= '0;
            drain       <= 1'b0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (state == ADDR || state == RESP) cnt <= cnt + 1'b1;
`endif
            case (state)
                IDLE: if (pick != 2'b00) begin
                    grant   <= pick;
                    state   <= ADDR;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    cnt   <= '0;
                    drain <= 1'b0;
`endif
                end
                ADDR: begin
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (aw_fin && w_fin) state <= RESP;
`ifdef ARB_TIMEOUT_EN
                    if (expire) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                        drain       <= 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (b_hs) begin
                        state      <= IDLE;
                        last_grant <= grant[1];
                        grant      <= 2'b00;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (expire) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                        drain       <= 1'b1;
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                ERR: begin
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (b_hs) begin
                        state      <= IDLE;
                        last_grant <= grant[1];
                        grant      <= 2'b00;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_wr_arbiter_2x1.sv
// Bench for axil_wr_arbiter_2x1: directed corner cases, then randomized traffic against a round-robin transaction model.
module tb_axil_wr_arbiter_2x1;
    localparam int AW = 32, DW = 32, SW = 4, N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] s_awaddr [2];
    logic [2:0]    s_awprot [2];
    logic          s_awvalid[2];
    logic [DW-1:0] s_wdata  [2];
    logic [SW-1:0] s_wstrb  [2];
    logic          s_wvalid [2];
    logic          s_bready [2];
    logic s0_axil_awready, s0_axil_wready, s0_axil_bvalid, s1_axil_awready, s1_axil_wready, s1_axil_bvalid;
    logic [1:0] s0_axil_bresp, s1_axil_bresp;
    logic [AW-1:0] m_axil_awaddr;
    logic [2:0]    m_axil_awprot;
    logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [DW-1:0] m_axil_wdata;
    logic [SW-1:0] m_axil_wstrb;
    logic [1:0]    m_axil_bresp, grant;
    logic          m_axil_bvalid, m_axil_bready, timeout_err;

    logic [1:0] s_awready, s_wready, s_bvalid;
    logic [1:0] s_bresp[2];
    assign s_awready = {s1_axil_awready, s0_axil_awready};
    assign s_wready  = {s1_axil_wready, s0_axil_wready};
    assign s_bvalid  = {s1_axil_bvalid, s0_axil_bvalid};
    assign s_bresp[0] = s0_axil_bresp;
    assign s_bresp[1] = s1_axil_bresp;

    axil_wr_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .s0_axil_awaddr(s_awaddr[0]), .s0_axil_awprot(s_awprot[0]), .s0_axil_awvalid(s_awvalid[0]),
        .s0_axil_awready(s0_axil_awready), .s0_axil_wdata(s_wdata[0]), .s0_axil_wstrb(s_wstrb[0]),
        .s0_axil_wvalid(s_wvalid[0]), .s0_axil_wready(s0_axil_wready), .s0_axil_bresp(s0_axil_bresp),
        .s0_axil_bvalid(s0_axil_bvalid), .s0_axil_bready(s_bready[0]),
        .s1_axil_awaddr(s_awaddr[1]), .s1_axil_awprot(s_awprot[1]), .s1_axil_awvalid(s_awvalid[1]),
        .s1_axil_awready(s1_axil_awready), .s1_axil_wdata(s_wdata[1]), .s1_axil_wstrb(s_wstrb[1]),
        .s1_axil_wvalid(s_wvalid[1]), .s1_axil_wready(s1_axil_wready), .s1_axil_bresp(s1_axil_bresp),
        .s1_axil_bvalid(s1_axil_bvalid), .s1_axil_bready(s_bready[1]),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot), .m_axil_awvalid(m_axil_awvalid),
        .m_axil_awready(m_axil_awready), .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .grant(grant), .timeout_err(timeout_err)
    );

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = '0; s_awprot[i] = '0; s_awvalid[i] = 1'b0;
            s_wdata[i] = '0; s_wstrb[i] = '0; s_wvalid[i] = 1'b0; s_bready[i] = 1'b0;
        end
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
    endtask

    // transaction tables and random-phase state
    logic [AW-1:0] t_addr[2][N+1];
    logic [2:0]    t_prot[2][N+1];
    logic [DW-1:0] t_data[2][N+1];
    logic [SW-1:0] t_strb[2][N+1];
    int idx[2], cyc[2], da[2], dw[2], gap[2], bcnt[2], st_b[2];
    bit act[2], aw_sent[2], w_sent[2];
    bit sl_aw, sl_w;
    int sl_ph, sl_bd, st_aw, st_w, w;
    logic [1:0] sl_bresp, mg;
    bit mlast;

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_grant", grant, 2'b00);
        check("rst_s_rdy", {s_awready, s_wready, s_bvalid}, 6'b0);
        check("rst_m_vld", {m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 3'b0);
        check("rst_bresp", {s0_axil_bresp, s1_axil_bresp}, 4'b0);
        check("rst_timeout", timeout_err, 1'b0);
        rst = 1'b0;

        // single write from s0, slave ready at once
        tick();
        s_awaddr[0] = 32'h100; s_wdata[0] = 32'hDEADBEEF; s_wstrb[0] = 4'hF;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        #1;
        check("sw_req_grant", grant, 2'b00);
        check("sw_req_mvld", m_axil_awvalid, 1'b0);
        tick();
        check("sw_grant", grant, 2'b01);
        check("sw_awaddr", m_axil_awaddr, 32'h100);
        check("sw_wdata", m_axil_wdata, 32'hDEADBEEF);
        check("sw_mvld", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
        check("sw_s0_rdy", {s0_axil_awready, s0_axil_wready}, 2'b11);
        tick();
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00; s_bready[0] = 1'b1;
        #1;
        check("sw_bvalid", s0_axil_bvalid, 1'b1);
        check("sw_bresp", s0_axil_bresp, 2'b00);
        check("sw_bready", m_axil_bready, 1'b1);
        tick();
        idle_inputs();
        #1;
        check("sw_end_grant", grant, 2'b00);

        // reset in ADDR after AW done, W still pending
        s_awaddr[0] = 32'h200; s_wdata[0] = 32'h1234_5678; s_wstrb[0] = 4'hF;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; m_axil_awready = 1'b1;
        tick();
        check("mr_grant", grant, 2'b01);
        tick();
        s_awvalid[0] = 1'b0; rst = 1'b1;
        #1;
        check("mr_aw_done", {m_axil_awvalid, m_axil_wvalid}, 2'b01);
        tick();
        rst = 1'b0; s_wvalid[0] = 1'b0;
        #1;
        check("mr_grant_clr", grant, 2'b00);
        check("mr_outs", {s_awready, s_wready, s_bvalid, m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 9'b0);
        s_awaddr[1] = 32'h300; s_wdata[1] = 32'hCAFE_F00D; s_wstrb[1] = 4'h3;
        s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1; m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        tick();
        check("mr_s1_grant", grant, 2'b10);
        check("mr_s1_addr", m_axil_awaddr, 32'h300);
        check("mr_s1_data", {m_axil_wdata, m_axil_wstrb}, {32'hCAFE_F00D, 4'h3});
        tick();
        s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0;
        m_axil_bvalid = 1'b1; s_bready[1] = 1'b1;
        #1;
        check("mr_s1_b", {s1_axil_bvalid, s0_axil_bvalid}, 2'b10);
        tick();
        idle_inputs();

`ifdef ARB_TIMEOUT_EN
        begin
            int n;
            s_awaddr[0] = 32'h400; s_wdata[0] = 32'h5555_AAAA; s_wstrb[0] = 4'hF;
            s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
            n = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (s0_axil_bvalid) break;
                n++;
            end
            check("to_cycles", n, 16);
            check("to_bresp", s0_axil_bresp, 2'b10);
            check("to_flag", timeout_err, 1'b1);
            check("to_mvld", {m_axil_awvalid, m_axil_wvalid}, 2'b00);
            check("to_accept", {s0_axil_awready, s0_axil_wready}, 2'b11);
            s_bready[0] = 1'b1;
            tick();
            idle_inputs();
            #1;
            check("to_drain", m_axil_bready, 1'b1);
            s_awaddr[1] = 32'h500; s_wdata[1] = 32'h0BAD_F00D; s_wstrb[1] = 4'hF;
            s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1; m_axil_awready = 1'b1; m_axil_wready = 1'b1;
            tick();
            check("to_s1_grant", grant, 2'b10);
            check("to_s1_addr", m_axil_awaddr, 32'h500);
            tick();
            s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0; m_axil_bvalid = 1'b1; s_bready[1] = 1'b1;
            #1;
            check("to_s1_b", {s1_axil_bvalid, s1_axil_bresp}, 3'b100);
            check("to_sticky", timeout_err, 1'b1);
            tick();
            idle_inputs();
        end
`endif

        // randomized traffic; previous winner was s1
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j <= N; j++) begin
                t_addr[i][j] = $urandom; t_data[i][j] = $urandom;
                t_prot[i][j] = 3'($urandom_range(0, 7)); t_strb[i][j] = 4'($urandom_range(0, 15));
            end
            idx[i] = 0; cyc[i] = 0; da[i] = 0; dw[i] = 0; gap[i] = 0; bcnt[i] = 0; st_b[i] = 0;
            act[i] = 1'b0; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
        end
        sl_aw = 1'b0; sl_w = 1'b0; sl_ph = 0; sl_bd = 0; st_aw = 0; st_w = 0; sl_bresp = 2'b00;
        mg = 2'b00; mlast = 1'b1;

        for (int c = 0; c < 4000 && !(bcnt[0] == N && bcnt[1] == N); c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && idx[i] < N) begin
                    if (gap[i] > 0) gap[i]--;
                    else begin
                        act[i] = 1'b1; cyc[i] = 0; aw_sent[i] = 1'b0; w_sent[i] = 1'b0;
                        da[i] = $urandom_range(0, 3); dw[i] = $urandom_range(0, 3);
                    end
                end
                s_awaddr[i] = t_addr[i][idx[i]]; s_awprot[i] = t_prot[i][idx[i]];
                s_wdata[i] = t_data[i][idx[i]]; s_wstrb[i] = t_strb[i][idx[i]];
                s_awvalid[i] = act[i] && !aw_sent[i] && cyc[i] >= da[i];
                s_wvalid[i] = act[i] && !w_sent[i] && cyc[i] >= dw[i];
                s_bready[i] = ($urandom_range(0, 3) != 0) || st_b[i] >= 2;
            end
            m_axil_awready = ($urandom_range(0, 3) != 0) || st_aw >= 2;
            m_axil_wready = ($urandom_range(0, 3) != 0) || st_w >= 2;
            if (sl_ph == 1) begin
                if (sl_bd == 0) begin
                    sl_ph = 2;
                    sl_bresp = $urandom_range(0, 1) ? 2'b10 : 2'b00;
                end else sl_bd--;
            end
            m_axil_bvalid = (sl_ph == 2);
            m_axil_bresp = (sl_ph == 2) ? sl_bresp : 2'b00;
            #1;

            w = int'(mg[1]);
            check("rnd_grant", grant, mg);
            for (int i = 0; i < 2; i++)
                if (!mg[i]) check("rnd_ungranted", {s_awready[i], s_wready[i], s_bvalid[i]}, 3'b0);
            if (mg == 2'b00) check("rnd_idle_mvld", {m_axil_awvalid, m_axil_wvalid}, 2'b00);
            if (m_axil_awvalid && m_axil_awready) begin
                check("rnd_dup_aw", sl_aw, 1'b0);
                check("rnd_awaddr", {m_axil_awaddr, m_axil_awprot}, {t_addr[w][idx[w]], t_prot[w][idx[w]]});
                sl_aw = 1'b1;
            end
            if (m_axil_wvalid && m_axil_wready) begin
                check("rnd_dup_w", sl_w, 1'b0);
                check("rnd_wdata", {m_axil_wdata, m_axil_wstrb}, {t_data[w][idx[w]], t_strb[w][idx[w]]});
                sl_w = 1'b1;
            end
            check("rnd_b_pair", m_axil_bvalid && m_axil_bready,
                  (s_bvalid[0] && s_bready[0]) || (s_bvalid[1] && s_bready[1]));
            if (m_axil_bvalid && m_axil_bready) begin
                sl_ph = 0; sl_aw = 1'b0; sl_w = 1'b0;
            end else if (sl_ph == 0 && sl_aw && sl_w) begin
                sl_ph = 1; sl_bd = $urandom_range(0, 2);
            end

            // round-robin: on a tie the master not served last wins
            if (mg == 2'b00) begin
                if (s_awvalid[0] && s_awvalid[1]) mg = mlast ? 2'b01 : 2'b10;
                else if (s_awvalid[0]) mg = 2'b01;
                else if (s_awvalid[1]) mg = 2'b10;
            end else if (s_bvalid[w] && s_bready[w]) begin
                mlast = (w == 1);
                mg = 2'b00;
            end

            for (int i = 0; i < 2; i++) begin
                if (s_bvalid[i] && s_bready[i]) begin
                    check("rnd_bresp", s_bresp[i], sl_bresp);
                    bcnt[i]++; idx[i]++; act[i] = 1'b0;
                    gap[i] = $urandom_range(0, 2);
                end else begin
                    if (s_awvalid[i] && s_awready[i]) aw_sent[i] = 1'b1;
                    if (s_wvalid[i] && s_wready[i]) w_sent[i] = 1'b1;
                end
                if (act[i]) cyc[i]++;
                st_b[i] = s_bready[i] ? 0 : st_b[i] + 1;
            end
            st_aw = m_axil_awready ? 0 : st_aw + 1;
            st_w = m_axil_wready ? 0 : st_w + 1;
        end
        check("rnd_s0_bcount", bcnt[0], N);
        check("rnd_s1_bcount", bcnt[1], N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
